add_arb_ctrl: RTL and testbench
===============================

# add_arb_ctrl

Round-robin arbiter and sequencer that shares one single-cycle-latency adder (start/valid, y = a + b) among N requesters. It accepts one request at a time, issues a one-cycle start pulse with the winner's operands, and waits for the adder's valid. It then returns the sum to the winner with a one-cycle response pulse. It sits between the requesting clients and the adder instance; the adder itself is unchanged.

## Interface
- N, 4, number of requesters (2..8)
- W, 16, operand/result width
- TIMEOUT, 8, max WAIT cycles before abort (used only with the timeout feature)

Ports:
- clk  input  1  clock, all logic on posedge
- rst_n  input  1  asynchronous, active-low reset
- req  input  N  per-requester request level; held with operands until own rsp_valid bit
- req_a  input  N*W  packed operand A, slice i = requester i
- req_b  input  N*W  packed operand B
- gnt  output  N  one-hot, high from ISSUE through RESP for the winner
- rsp_valid  output  N  one-hot, one-cycle pulse to the winner
- rsp_y  output  W  result, valid while any rsp_valid bit is high
- rsp_err  output  1  high with rsp_valid on timeout abort
- add_start  output  1  one-cycle start to adder
- add_a, add_b  output  W  adder operands, stable in ISSUE
- add_y  input  W  adder result
- add_valid  input  1  adder result valid

## Operation
- Moore FSM (registered state): IDLE → ISSUE → WAIT → RESP → IDLE.
- IDLE:
  - If req != 0, pick the winner with round-robin starting at pointer ptr (search ptr, ptr+1, … mod N).
  - Register winner index and its operands, then go to ISSUE.
  - If req == 0, stay in IDLE.
- ISSUE:
  - add_start=1; add_a/add_b driven from the operand registers.
  - Go to WAIT.
- WAIT:
  - On add_valid, capture add_y and go to RESP.
  - Otherwise stay.
- RESP:
  - rsp_valid[winner]=1 and rsp_y = captured sum.
  - ptr ← (winner+1) mod N; go to IDLE.
- The sum is (a+b) mod 2^W; carry is discarded.
- add_valid outside WAIT is ignored.
- Changes to req or operands after capture are ignored until the next IDLE.
- A requester that keeps req high after its rsp_valid is treated as a new request.
- Reset: state=IDLE, ptr=0, and all outputs 0 (gnt, rsp_valid, rsp_y, rsp_err, add_start, add_a, add_b).
- Reset mid-operation discards the in-flight request; a held req re-arbitrates after release.

## Timing
- req sampled at edge E0 (in IDLE):
  - ISSUE in the cycle after E0.
  - Adder asserts valid the next cycle (WAIT).
  - RESP in the cycle after E2.
- rsp_valid is high exactly 3 cycles after the edge that sampled req.
- Minimum turnaround is 4 cycles per transaction, including the IDLE cycle.
- gnt is asserted during ISSUE, WAIT and RESP, and low in IDLE.
- Simultaneous requests: exactly one is granted per transaction. With all N held continuously, grants go in order ptr, ptr+1, …; each requester waits at most N transactions.

## Configuration
- ADD_ARB_TIMEOUT_EN defined:
  - A WAIT-cycle counter runs from 0.
  - If TIMEOUT cycles pass without add_valid, go to RESP with rsp_err=1 and rsp_y=0.
  - A late add_valid is then ignored (IDLE).
  - Counter clears on entry to WAIT and on reset.
- Not defined:
  - WAIT holds indefinitely.
  - rsp_err is tied 0 and the counter is not present.

## Structure
- Package add_arb_pkg holds:
  - state enum typedef (IDLE, ISSUE, WAIT, RESP)
  - default N/W/TIMEOUT localparams
  - index-width function clog2-based
- Sub-module add_arb_rr_pick: combinational round-robin picker.
  - Inputs: req, ptr. Outputs: grant_onehot, grant_idx, any.
- The top holds the FSM, operand registers, ptr and the optional counter.

## Test plan
- Single request, with req[2]=1, a=100, b=23:
  - add_start pulses once.
  - rsp_valid=4'b0100 three cycles after sampling, rsp_y=123.
- All four requesters held from ptr=0:
  - Grants occur in order 0,1,2,3,0.
  - Each rsp_y matches its own a+b.
- Wrap: a=16'hFFFF, b=16'h0002 → rsp_y=16'h0001, rsp_err=0.
- Reset mid-transaction: assert rst_n=0 during WAIT.
  - All outputs 0 immediately.
  - After release with req[1] held, it is re-granted; ptr restarts at 0.
- Timeout (with ADD_ARB_TIMEOUT_EN), adder valid forced low: after TIMEOUT=8 WAIT cycles, rsp_valid pulses with rsp_err=1 and rsp_y=0.
- Spurious add_valid in IDLE: no rsp_valid and no state change.

Source files
------------

// File: rtl/add_arb_pkg.sv
// Shared types and defaults for the add_arb round-robin adder sequencer.
package add_arb_pkg;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  localparam int N_DEF       = 4;
  localparam int W_DEF       = 16;
  localparam int TIMEOUT_DEF = 8;

  // Index width for n requesters; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/add_arb_rr_pick.sv
// Combinational round-robin picker: first asserted req at or after ptr, wrapping mod N.
module add_arb_rr_pick
  import add_arb_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int IW = idx_w(N_DEF)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  grant_onehot,
  output logic [IW-1:0] grant_idx,
  output logic          any
);

  int   idx;
  logic found;

  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    found        = 1'b0;
    idx          = 0;
    any          = |req;
    for (int k = 0; k < N; k++) begin
      idx = (int'(ptr) + k) % N;
      if (!found && req[idx]) begin
        found             = 1'b1;
        grant_idx         = IW'(idx);
        grant_onehot[idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/add_arb_ctrl.sv
// Round-robin arbiter/sequencer sharing one start/valid adder among N requesters.
// Optional ADD_ARB_TIMEOUT_EN aborts a WAIT that exceeds TIMEOUT cycles with rsp_err.
module add_arb_ctrl
  import add_arb_pkg::*;
#(
  parameter int N       = N_DEF,
  parameter int W       = W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N-1:0]        req,
  input  logic [N-1:0][W-1:0] req_a,
  input  logic [N-1:0][W-1:0] req_b,
  output logic [N-1:0]        gnt,
  output logic [N-1:0]        rsp_valid,
  output logic [W-1:0]        rsp_y,
  output logic                rsp_err,
  output logic                add_start,
  output logic [W-1:0]        add_a,
  output logic [W-1:0]        add_b,
  input  logic [W-1:0]        add_y,
  input  logic                add_valid
);

  localparam int IW = idx_w(N);

  state_e          state, state_nxt;
  logic [IW-1:0]   ptr, win, pk_idx;
  logic [N-1:0]    win_oh, pk_onehot;
  logic            pk_any, tmo;
  logic [W-1:0]    a_q, b_q, y_q;

  add_arb_rr_pick #(.N(N), .IW(IW)) u_pick (
    .req          (req),
    .ptr          (ptr),
    .grant_onehot (pk_onehot),
    .grant_idx    (pk_idx),
    .any          (pk_any)
  );

`ifdef ADD_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] wcnt;
  logic          err_q;

  assign tmo     = (state == WAIT) && !add_valid && (wcnt == CW'(TIMEOUT - 1));
  assign rsp_err = (state == RESP) && err_q;

  // Counter is zeroed while in ISSUE so every WAIT starts counting from 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt  <= '0;
      err_q <= 1'b0;
    end else begin
      if (state == ISSUE)     wcnt <= '0;
      else if (state == WAIT) wcnt <= wcnt + CW'(1);
      if (state == WAIT && add_valid) err_q <= 1'b0;
      else if (tmo)                   err_q <= 1'b1;
    end
  end
`else
  assign tmo     = 1'b0;
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (pk_any) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (add_valid || tmo) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Winner and operands are frozen at the IDLE decision; later req changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr    <= '0;
      win    <= '0;
      win_oh <= '0;
      a_q    <= '0;
      b_q    <= '0;
      y_q    <= '0;
    end else begin
      if (state == IDLE && pk_any) begin
        win    <= pk_idx;
        win_oh <= pk_onehot;
        a_q    <= req_a[pk_idx];
        b_q    <= req_b[pk_idx];
      end
      if (state == WAIT && add_valid) y_q <= add_y;
      else if (tmo)                   y_q <= '0;
      if (state == RESP) ptr <= (win == IW'(N - 1)) ? '0 : win + IW'(1);
    end
  end

  assign gnt       = (state != IDLE)  ? win_oh : '0;
  assign rsp_valid = (state == RESP)  ? win_oh : '0;
  assign rsp_y     = (state == RESP)  ? y_q    : '0;
  assign add_start = (state == ISSUE);
  assign add_a     = (state == ISSUE) ? a_q    : '0;
  assign add_b     = (state == ISSUE) ? b_q    : '0;

endmodule

// File: tb/tb_add_arb_ctrl.sv
// Scoreboard bench for add_arb_ctrl: phase-level round-robin model feeds an expected queue,
// a negedge monitor pops and compares every response and adder start.
module tb_add_arb_ctrl;
  localparam int N  = 4;
  localparam int W  = 16;
  localparam int TO = 8;

  typedef struct {
    int         idx;
    logic [W-1:0] a, b, y;
    logic       err;
    int         dly;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [N-1:0]        req = '0;
  logic [N-1:0][W-1:0] req_a = '0, req_b = '0;
  logic [N-1:0]        gnt, rsp_valid;
  logic [W-1:0]        rsp_y, add_a, add_b;
  logic                rsp_err, add_start;
  logic [W-1:0]        add_y = '0;
  logic                add_valid = 1'b0;

  exp_t         q[$];
  int           n_cmp = 0, n_bad = 0;
  int           mptr = 0;
  int           lat = 1;
  bit           spur = 0;
  logic [W-1:0] opa[N][2], opb[N][2];
  int           cnt[N];

  add_arb_ctrl #(.N(N), .W(W), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .rsp_valid(rsp_valid), .rsp_y(rsp_y), .rsp_err(rsp_err),
    .add_start(add_start), .add_a(add_a), .add_b(add_b),
    .add_y(add_y), .add_valid(add_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Adder model: result valid `lat` cycles after the start cycle; lat==0 means it never answers.
  int           rem = 0;
  logic [W-1:0] ysum;
  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem = 0; add_valid = 1'b0; add_y = '0;
    end else if (spur) begin
      add_valid = 1'b1; add_y = 16'($urandom);
    end else if (add_start) begin
      add_valid = 1'b0; add_y = 16'($urandom);
      rem = lat; ysum = add_a + add_b;
    end else if (rem > 0) begin
      rem--;
      add_valid = (rem == 0);
      add_y = (rem == 0) ? ysum : 16'($urandom);
    end else begin
      add_valid = 1'b0; add_y = 16'($urandom);
    end
  end

  // Monitor
  int cyc = 0, issue_cyc = 0;
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst_n) begin
      if (add_start) begin
        issue_cyc = cyc;
        if (q.size() > 0) begin
          chk("add_a", add_a, q[0].a);
          chk("add_b", add_b, q[0].b);
          chk("gnt_issue", gnt, 64'(1) << q[0].idx);
        end
      end
      if (rsp_valid != '0) begin
        if (q.size() == 0) begin
          chk("unexpected_rsp", rsp_valid, 0);
        end else begin
          e = q.pop_front();
          chk("rsp_valid", rsp_valid, 64'(1) << e.idx);
          chk("rsp_y", rsp_y, e.y);
          chk("rsp_err", rsp_err, e.err);
          chk("gnt_resp", gnt, rsp_valid);
          chk("rsp_latency", cyc - issue_cyc, e.dly);
        end
      end
    end
  end

  // Reference: serve every pending request of the phase in round-robin order from mptr.
  task automatic run_phase(input logic [N-1:0] mask);
    int   left[N], used[N];
    int   total, budget, j, s;
    bit   done;
    exp_t e;
    total = 0;
    for (int i = 0; i < N; i++) begin
      left[i] = mask[i] ? cnt[i] : 0;
      used[i] = 0;
      total += left[i];
    end
    while (total > 0) begin
      done = 0;
      for (int k = 0; k < N; k++) begin
        j = (mptr + k) % N;
        if (!done && left[j] > 0) begin
          done = 1;
          e.idx = j;
          e.a = opa[j][cnt[j] - left[j]];
          e.b = opb[j][cnt[j] - left[j]];
          s = int'(e.a) + int'(e.b);
          e.y = W'(s % 65536);
          e.err = 1'b0;
          e.dly = 1 + lat;
`ifdef ADD_ARB_TIMEOUT_EN
          if (lat == 0) begin e.y = '0; e.err = 1'b1; e.dly = TO + 1; end
`endif
          q.push_back(e);
          left[j]--; total--;
          mptr = (j + 1) % N;
        end
      end
    end
    for (int i = 0; i < N; i++)
      if (mask[i]) begin req_a[i] = opa[i][0]; req_b[i] = opb[i][0]; end
    req = req | mask;
    budget = 0;
    while ((req != '0 || q.size() != 0) && budget < 400) begin
      @(negedge clk);
      budget++;
      for (int i = 0; i < N; i++)
        if (rsp_valid[i] && req[i]) begin
          used[i]++;
          if (used[i] < cnt[i]) begin
            req_a[i] = opa[i][used[i]]; req_b[i] = opb[i][used[i]];
          end else req[i] = 1'b0;
        end
    end
    chk("phase_complete", budget < 400, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    cnt[i] = 1; opa[i][0] = a; opb[i][0] = b;
  endtask

  initial begin
    int bud;
    logic [N-1:0] m;
    #2;
    chk("reset_outputs", {gnt, rsp_valid, rsp_y, rsp_err, add_start, add_a, add_b}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // All four held from ptr 0; requester 0 asks twice -> 0,1,2,3,0
    lat = 1;
    for (int i = 0; i < N; i++) begin
      cnt[i] = (i == 0) ? 2 : 1;
      for (int k = 0; k < 2; k++) begin opa[i][k] = 16'($urandom); opb[i][k] = 16'($urandom); end
    end
    run_phase(4'b1111);

    set_req(2, 16'd100, 16'd23);
    run_phase(4'b0100);
    set_req(3, 16'hFFFF, 16'h0002);
    run_phase(4'b1000);

    // Spurious add_valid while idle must be ignored
    spur = 1; @(negedge clk); spur = 0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("idle_gnt", gnt, 0);
      chk("idle_start", add_start, 0);
    end

    for (int p = 0; p < 12; p++) begin
      m = N'($urandom_range(1, 15));
      lat = $urandom_range(1, 3);
      for (int i = 0; i < N; i++) begin
        cnt[i] = $urandom_range(1, 2);
        for (int k = 0; k < 2; k++) begin opa[i][k] = 16'($urandom); opb[i][k] = 16'($urandom); end
      end
      run_phase(m);
    end

`ifdef ADD_ARB_TIMEOUT_EN
    lat = 0;
    set_req(0, 16'h1234, 16'h1111);
    run_phase(4'b0001);
`endif

    // Reset during WAIT: serve 1 alone so ptr=2, then 3 would win; reset drops it and ptr.
    lat = 1;
    set_req(1, 16'd7, 16'd8);
    run_phase(4'b0010);
    lat = 3;
    set_req(1, 16'd40, 16'd2);
    set_req(3, 16'd500, 16'd5);
    req_a[1] = 16'd40; req_b[1] = 16'd2; req_a[3] = 16'd500; req_b[3] = 16'd5;
    req = 4'b1010;
    bud = 0;
    while (!add_start && bud < 20) begin @(negedge clk); bud++; end
    chk("reset_test_issue", add_start, 1);
    @(negedge clk);
    chk("pre_reset_gnt", gnt, 4'b1000);
    rst_n = 1'b0;
    #1;
    chk("midreset_outputs", {gnt, rsp_valid, rsp_y, rsp_err, add_start, add_a, add_b}, 0);
    q.delete();
    mptr = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_phase(4'b1010);

    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
